// File: rtl/input_arb_rr_pkg.sv
// Shared types and constants for the round-robin AXI read arbiter.
package input_arb_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         AXI_ADDR_W = 40;

    // Channel index width; a single channel still needs one bit to carry an index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_arb_rr_if.sv
// AXI read-address and read-data channel bundle between the arbiter and the fabric.
interface input_arb_rr_if #(
    parameter int DW = 64
);
    logic [39:0]   araddr;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rd_data;
    logic          rvalid;
    logic          rlast;
    logic [1:0]    rresp;
    logic          rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rd_data, rvalid, rlast, rresp
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rd_data, rvalid, rlast, rresp
    );
endinterface

// File: rtl/input_arb_rr_rr_penc.sv
// Round-robin priority encoder: first requester after 'last', wrapping.
module rr_penc #(
    parameter int NP = 4,
    parameter int IW = 2
) (
    input  logic [NP-1:0] req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant
);

    int idx;

    // Walk the search order backwards so the earliest candidate is written last and wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = NP; i >= 1; i--) begin
            idx = (int'(last) + i) % NP;
            if (req[idx]) begin
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/input_arb_rr.sv
// Round-robin arbiter granting NP read channels fixed-length AXI bursts.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no burst; grant the next requester round-robin from last
//   ADDR    | AR request outstanding, araddr held until arready
//   DATA    | R beats routed to the granted channel until NTFR beats seen
module input_arb_rr
    import input_arb_rr_pkg::*;
#(
    parameter int NP   = 4,
    parameter int DW   = 64,
    parameter int AW   = 24,
    parameter int NTFR = 64
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [NP-1:0]       rreq,
    input  logic [AW-1:0]       radr  [NP],
    output logic [NP-1:0]       rack,
    output logic [DW-1:0]       rdata [NP],
    input  logic [39:0]         baseadr,
    input_arb_rr_if.master      axi,
    output logic                busy,
    output logic                err,
    input  logic                err_clr
);

    localparam int NB = $clog2(NTFR * DW / 8);
    localparam int IW = idx_width(NP);
    localparam int CW = $clog2(NTFR) + 1;

    localparam logic [CW-1:0]         LAST_BEAT  = CW'(NTFR - 1);
    localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~((AXI_ADDR_W'(1) << NB) - AXI_ADDR_W'(1));

    state_e                  state_q, state_d;
    logic [IW-1:0]           ch_q, ch_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [AXI_ADDR_W-1:0]   araddr_q, araddr_d;
    logic                    err_q, err_d;

    logic [IW-1:0]           grant;
    logic [AW-1:0]           sel_adr;
    logic                    beat;
    logic                    last_beat;
    logic                    err_event;

    rr_penc #(
        .NP (NP),
        .IW (IW)
    ) u_rr_penc (
        .req   (rreq),
        .last  (last_q),
        .grant (grant)
    );

    // Pick the address of the channel the encoder would grant this cycle.
    always_comb begin
        sel_adr = '0;
        for (int i = 0; i < NP; i++) begin
            if (grant == IW'(i)) begin
                sel_adr = radr[i];
            end
        end
    end

    assign beat      = (state_q == ST_DATA) && axi.rvalid;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign err_event = beat && ((axi.rlast != last_beat) || (axi.rresp != RESP_OKAY));

    // Next-state and datapath updates for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        araddr_d = araddr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|rreq) begin
                    ch_d     = grant;
                    // Address is frozen at grant so it stays stable through the AR handshake.
                    araddr_d = (AXI_ADDR_W'(sel_adr) & ALIGN_MASK) + baseadr;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.rvalid) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        last_d  = ch_q;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error: a new error event beats a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_event) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers; reset leaves last = NP-1 so channel 0 wins first.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            last_q   <= IW'(NP - 1);
            cnt_q    <= '0;
            araddr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
            err_q    <= err_d;
        end
    end

    // Route the R channel to the granted channel only while a burst is in DATA.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            rack[i]  = 1'b0;
            rdata[i] = '0;
            if ((state_q == ST_DATA) && (ch_q == IW'(i))) begin
                rack[i]  = axi.rvalid;
                rdata[i] = axi.rd_data;
            end
        end
    end

    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'(NTFR - 1);
    assign axi.arvalid = (state_q == ST_ADDR);
    assign axi.rready  = (state_q == ST_DATA);
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_input_arb_rr.sv
// Randomized self-checking bench for input_arb_rr with a behavioural grant/error model.
module tb_input_arb_rr;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int AW   = 24;
    localparam int NTFR = 4;
    localparam int NB   = $clog2(NTFR * DW / 8);

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic [NP-1:0] rreq;
    logic [AW-1:0] radr  [NP];
    logic [NP-1:0] rack;
    logic [DW-1:0] rdata [NP];
    logic [39:0]   baseadr;
    logic          busy, err, err_clr;

    logic [NP-1:0] rreq2;
    logic [AW-1:0] radr2  [NP];
    logic [NP-1:0] rack2;
    logic [DW-1:0] rdata2 [NP];
    logic [39:0]   baseadr2;
    logic          busy2, err2, err_clr2;

    input_arb_rr_if #(.DW(DW)) axi ();
    input_arb_rr_if #(.DW(DW)) axi2 ();

    always #5 aclk = ~aclk;

    input_arb_rr #(.NP(NP), .DW(DW), .AW(AW), .NTFR(NTFR)) dut (
        .aclk(aclk), .arst(arst), .rreq(rreq), .radr(radr), .rack(rack), .rdata(rdata),
        .baseadr(baseadr), .axi(axi), .busy(busy), .err(err), .err_clr(err_clr)
    );

    input_arb_rr #(.NP(NP), .DW(64), .AW(AW), .NTFR(64)) dut64 (
        .aclk(aclk), .arst(arst), .rreq(rreq2), .radr(radr2), .rack(rack2), .rdata(rdata2),
        .baseadr(baseadr2), .axi(axi2), .busy(busy2), .err(err2), .err_clr(err_clr2)
    );

    int n_chk = 0;
    int n_err = 0;
    int last_m;
    bit err_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_quiet_idle(input string tag);
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
        chk({tag, "_rready"}, 64'(axi.rready), 64'd0);
        chk({tag, "_rack"}, 64'(rack), 64'd0);
    endtask

    // One full burst from IDLE; expectations come from the round-robin rule and address arithmetic.
    task automatic do_burst(input logic [NP-1:0] pat, input int stall, input int err_mode,
                            input int clr_beat, input bit drop_req);
        int            ch;
        int            gaps;
        logic [39:0]   exp_adr;
        logic [63:0]   d;
        bit            ev;
        ch = -1;
        for (int k = 1; k <= NP; k++) begin
            int c;
            c = (last_m + k) % NP;
            if (pat[c] && ch < 0) ch = c;
        end
        exp_adr = 40'((longint'(radr[ch]) >> NB) << NB) + baseadr;
        rreq = pat;
        #1;
        chk("pre_grant_busy", 64'(busy), 64'd0);
        chk("pre_grant_arvalid", 64'(axi.arvalid), 64'd0);
        step;
        if (drop_req) rreq = '0;
        axi.arready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            chk("stall_arvalid", 64'(axi.arvalid), 64'd1);
            chk("stall_araddr", 64'(axi.araddr), 64'(exp_adr));
            chk("stall_rready", 64'(axi.rready), 64'd0);
            chk("stall_rack", 64'(rack), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            step;
        end
        axi.arready = 1'b1;
        #1;
        chk("ar_arvalid", 64'(axi.arvalid), 64'd1);
        chk("ar_araddr", 64'(axi.araddr), 64'(exp_adr));
        chk("ar_arlen", 64'(axi.arlen), 64'(NTFR - 1));
        step;
        axi.arready = 1'b0;
        for (int b = 0; b < NTFR; b++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                axi.rvalid  = 1'b0;
                axi.rd_data = {$urandom(), $urandom()};
                #1;
                chk("gap_rready", 64'(axi.rready), 64'd1);
                chk("gap_rack", 64'(rack), 64'd0);
                step;
            end
            d = {$urandom(), $urandom()};
            axi.rvalid  = 1'b1;
            axi.rd_data = d;
            axi.rlast   = (b == NTFR - 1);
            axi.rresp   = 2'b00;
            if (err_mode == 1 && b == 1) axi.rlast = 1'b1;
            if (err_mode == 2 && b == 2) axi.rresp = 2'b10;
            if (err_mode == 3) begin
                if ($urandom_range(0, 7) == 0) axi.rlast = ~axi.rlast;
                if ($urandom_range(0, 7) == 0) axi.rresp = 2'($urandom_range(1, 3));
            end
            err_clr = (b == clr_beat);
            ev = (axi.rlast != (b == NTFR - 1)) || (axi.rresp != 2'b00);
            #1;
            chk("beat_rready", 64'(axi.rready), 64'd1);
            chk("beat_rack", 64'(rack), 64'(1) << ch);
            for (int c = 0; c < NP; c++) begin
                chk("beat_rdata", rdata[c], (c == ch) ? d : 64'd0);
            end
            step;
            err_m = ev ? 1'b1 : (err_clr ? 1'b0 : err_m);
            err_clr    = 1'b0;
            axi.rvalid = 1'b0;
            axi.rresp  = 2'b00;
            axi.rlast  = 1'b0;
            chk("beat_err", 64'(err), 64'(err_m));
        end
        rreq   = '0;
        last_m = ch;
        chk_quiet_idle("post_burst");
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        err_m   = 1'b0;
        chk("err_clr", 64'(err), 64'(err_m));
    endtask

    task automatic rand_addrs;
        for (int i = 0; i < NP; i++) radr[i] = AW'($urandom());
        baseadr = 40'({$urandom(), $urandom()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rreq        = '0;
        err_clr     = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rresp   = 2'b00;
        axi.rd_data = '0;
        rreq2        = 4'b0100;
        err_clr2     = 1'b0;
        axi2.arready = 1'b0;
        axi2.rvalid  = 1'b0;
        axi2.rlast   = 1'b0;
        axi2.rresp   = 2'b00;
        axi2.rd_data = '0;
        baseadr2     = 40'h10_00;
        for (int i = 0; i < NP; i++) radr2[i] = 24'h00_0000;
        radr2[2] = 24'h00_0123;
        rand_addrs();

        repeat (3) step;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
        chk("rst_rready", 64'(axi.rready), 64'd0);
        arst   = 1'b0;
        last_m = NP - 1;
        err_m  = 1'b0;

        // Wide-burst instance: channel 2 address aligns to 512 bytes.
        step;
        step;
        chk("b64_arvalid", 64'(axi2.arvalid), 64'd1);
        chk("b64_araddr", 64'(axi2.araddr), 64'h1000);
        chk("b64_arlen", 64'(axi2.arlen), 64'd63);

        baseadr = 40'h12_3456_7890;
        for (int n = 0; n < 5; n++) do_burst(4'b1111, 0, 0, -1, 1'b0);

        do_burst(4'b0100, 5, 0, -1, 1'b0);
        do_burst(4'b1010, 1, 0, -1, 1'b1);

        do_burst(4'b0001, 0, 1, -1, 1'b0);
        do_burst(4'b0010, 0, 0, -1, 1'b0);
        clear_err();
        do_burst(4'b1000, 0, 2, 2, 1'b0);
        clear_err();

        // Reset in DATA after one errored beat; next grant must restart at channel 0.
        rand_addrs();
        rreq = 4'b1110;
        step;
        axi.arready = 1'b1;
        step;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rresp   = 2'b10;
        axi.rd_data = 64'hDEAD_BEEF_0000_0001;
        step;
        err_m = 1'b1;
        chk("mid_err", 64'(err), 64'(err_m));
        arst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_arvalid", 64'(axi.arvalid), 64'd0);
        chk("arst_rready", 64'(axi.rready), 64'd0);
        chk("arst_rack", 64'(rack), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        rreq       = '0;
        step;
        arst   = 1'b0;
        last_m = NP - 1;
        err_m  = 1'b0;
        do_burst(4'b1111, 0, 0, -1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            rand_addrs();
            if ($urandom_range(0, 3) == 0) begin
                step;
                chk_quiet_idle("idle_noreq");
            end
            if (err_m && $urandom_range(0, 1) == 0) clear_err();
            do_burst(NP'($urandom_range(1, 15)), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? 3 : 0,
                     ($urandom_range(0, 5) == 0) ? $urandom_range(0, NTFR - 1) : -1,
                     1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
